// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: arbitrates memory wait, halt drain, taken
// branch and load-use stalls into per-stage write enables for the 5-stage core.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W        = 4,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             ifid_valid,
  input  logic             id_branch_taken,
  input  logic             id_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam int unsigned     DC_W       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYCLES - 1);

  state_t          cur_state, nxt_state;
  state_t          ret_state, nxt_ret;
  state_t          eff_state;
  logic [DC_W-1:0] drain_cnt, nxt_drain;
  logic            freeze;
  logic            hazard;

  assign state = cur_state;

  always_comb begin
    freeze = (imem_busy | dmem_busy) && (cur_state != HALTED);
    hazard = ifid_valid & idex_memread & (idex_rd != '0) &
             ((idex_rd == ifid_rs) | (ifid_uses_rt & (idex_rd == ifid_rt)));
    // Leaving MEM_WAIT applies the return state's rules in the same cycle.
    eff_state = (cur_state == MEM_WAIT) ? ret_state : cur_state;

    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    halted      = 1'b0;
    nxt_state   = cur_state;
    nxt_ret     = ret_state;
    nxt_drain   = drain_cnt;

    if (cur_state == HALTED) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      halted   = 1'b1;
    end else if (freeze) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      nxt_state = MEM_WAIT;
      nxt_ret   = eff_state;
    end else begin
      case (eff_state)
        DRAIN: begin
          pc_en       = 1'b0;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (drain_cnt == '0) begin
            nxt_state = HALTED;
          end else begin
            nxt_state = DRAIN;
            nxt_drain = drain_cnt - 1'b1;
          end
        end
        default: begin
          nxt_state = RUN;
          if (hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_halt & ifid_valid) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            nxt_state  = DRAIN;
            nxt_drain  = DRAIN_LOAD;
          end else if (id_branch_taken & ifid_valid) begin
            ifid_flush = 1'b1;
          end
        end
      endcase
    end

    if (rst) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_bubble = 1'b0;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= RUN;
      ret_state <= RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      ret_state <= nxt_ret;
      drain_cnt <= nxt_drain;
      if (!pc_en && (cur_state != HALTED) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed test-plan steps followed
// by random traffic, all checked against a behavioural model of the pipeline.
module tb_pipe_hazard_ctrl;

  localparam int unsigned DRAIN_N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_busy, dmem_busy, idex_memread;
  logic [3:0] idex_rd, ifid_rs, ifid_rt;
  logic       ifid_uses_rt, ifid_valid, id_branch_taken, id_halt;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
  logic [1:0] state;
  logic       halted;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // Model: halted flag, cycles of drain left (-1 = not draining), whether the
  // previous cycle was frozen, and the saturating stall tally.
  bit m_halted;
  int m_drain_left;
  bit m_waiting;
  int m_stalls;

  logic [6:0] exp_en;
  logic       exp_halt;
  logic [1:0] exp_state;

  pipe_hazard_ctrl #(.REG_W(4), .DRAIN_CYCLES(DRAIN_N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt), .ifid_valid(ifid_valid),
    .id_branch_taken(id_branch_taken), .id_halt(id_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .state(state), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; imem_busy = 0; dmem_busy = 0; idex_memread = 0;
    idex_rd = 0; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0;
    ifid_valid = 0; id_branch_taken = 0; id_halt = 0;
  endtask

  task automatic model_reset();
    m_halted = 0; m_drain_left = -1; m_waiting = 0; m_stalls = 0;
  endtask

  // Enable vector order: {pc, ifid, flush, idex, bubble, exmem, memwb}
  task automatic predict(output bit frz, output bit hz);
    frz = (imem_busy | dmem_busy) && !m_halted;
    hz  = ifid_valid && idex_memread && idex_rd != 0 &&
          (idex_rd == ifid_rs || (ifid_uses_rt && idex_rd == ifid_rt));
    exp_halt  = 0;
    exp_state = m_halted ? 2'd3 : m_waiting ? 2'd1 : (m_drain_left >= 0) ? 2'd2 : 2'd0;
    if (rst)                                exp_en = 7'b1101011;
    else if (m_halted) begin                exp_en = 7'b0000000; exp_halt = 1; end
    else if (frz)                           exp_en = 7'b0000000;
    else if (m_drain_left >= 0)             exp_en = 7'b0111111;
    else if (hz)                            exp_en = 7'b0001111;
    else if (id_halt && ifid_valid)         exp_en = 7'b0111011;
    else if (id_branch_taken && ifid_valid) exp_en = 7'b1111011;
    else                                    exp_en = 7'b1101011;
  endtask

  task automatic cycle();
    bit frz, hz;
    @(negedge clk);
    predict(frz, hz);
    check("enables", {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en}, exp_en);
    check("state", state, exp_state);
    check("halted", halted, exp_halt);
    check("stall_cnt", stall_cnt, m_stalls);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (!m_halted && !exp_en[6] && m_stalls < 65535) m_stalls++;
      if (m_halted) ;
      else if (frz) m_waiting = 1;
      else begin
        m_waiting = 0;
        if (m_drain_left == 0) begin m_halted = 1; m_drain_left = -1; end
        else if (m_drain_left > 0) m_drain_left--;
        else if (!hz && id_halt && ifid_valid) m_drain_left = DRAIN_N - 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    model_reset();
    cycle();
    rst = 0;

    // Load-use hazard, then the same with rd=r0.
    idex_memread = 1; idex_rd = 3; ifid_rs = 3; ifid_valid = 1;
    cycle();
    idle(); cycle();
    check("loaduse_stall_cnt", stall_cnt, 1);
    idex_memread = 1; idex_rd = 0; ifid_rs = 0; ifid_valid = 1;
    cycle();
    // rt match only counts when rt is read.
    idex_rd = 5; ifid_rs = 1; ifid_rt = 5; ifid_uses_rt = 0; cycle();
    ifid_uses_rt = 1; cycle();

    // Branch alone, then branch with a simultaneous hazard.
    idle(); ifid_valid = 1; id_branch_taken = 1; cycle();
    idex_memread = 1; idex_rd = 7; ifid_rs = 7; cycle();
    ifid_valid = 0; cycle();

    // Memory wait for 4 cycles, then release.
    idle(); dmem_busy = 1;
    repeat (4) cycle();
    dmem_busy = 0; cycle();
    // Busy with a hazard pending: freeze wins, hazard applies on release.
    dmem_busy = 1; idex_memread = 1; idex_rd = 2; ifid_rs = 2; ifid_valid = 1;
    repeat (2) cycle();
    dmem_busy = 0; cycle();

    // Halt drain to HALTED, memory busy ignored there, then reset out.
    idle(); ifid_valid = 1; id_halt = 1; cycle();
    idle(); repeat (3) cycle();
    imem_busy = 1; repeat (2) cycle();
    check("halted_port", halted, 1'b1);
    idle(); do_reset(); cycle();

    // Halt drain with a 2-cycle instruction-memory stall in the middle.
    ifid_valid = 1; id_halt = 1; cycle();
    idle(); cycle();
    imem_busy = 1; repeat (2) cycle();
    imem_busy = 0; repeat (4) cycle();

    // Reset during MEM_WAIT entered from DRAIN.
    do_reset();
    ifid_valid = 1; id_halt = 1; cycle();
    idle(); dmem_busy = 1; repeat (2) cycle();
    rst = 1; cycle();
    idle(); cycle();
    check("post_reset_state", state, 2'd0);

    // Random traffic with a small register space to provoke hazards.
    for (int i = 0; i < 4000; i++) begin
      rst             = ($urandom_range(0, 199) == 0);
      imem_busy       = ($urandom_range(0, 7) == 0);
      dmem_busy       = ($urandom_range(0, 7) == 0);
      idex_memread    = $urandom_range(0, 1);
      idex_rd         = 4'($urandom_range(0, 3));
      ifid_rs         = 4'($urandom_range(0, 3));
      ifid_rt         = 4'($urandom_range(0, 3));
      ifid_uses_rt    = $urandom_range(0, 1);
      ifid_valid      = ($urandom_range(0, 3) != 0);
      id_branch_taken = $urandom_range(0, 1);
      id_halt         = ($urandom_range(0, 49) == 0);
      cycle();
    end

    // Stall counter saturation under a long memory wait.
    do_reset();
    dmem_busy = 1;
    for (int i = 0; i < 65540; i++) cycle();
    check("sat_stall_cnt", stall_cnt, 16'hFFFF);
    dmem_busy = 0; idex_memread = 1; idex_rd = 4; ifid_rs = 4; ifid_valid = 1;
    cycle();
    idle(); cycle();
    check("sat_hold", stall_cnt, 16'hFFFF);
    do_reset(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 16-bit 5-stage core. It drives the write enables of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, the IF/ID flush bit, and the ID/EX bubble. It arbitrates between four stall/flush sources: memory wait, halt drain, taken branch, and load-use hazard. It sequences end-of-program drain into a terminal halted state.

Parameters:
REG_W, 4, register-specifier width (16 architectural registers; r0 hard-wired zero)
DRAIN_CYCLES, 3, non-frozen cycles after HLT decode before HALTED is entered
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_busy  input  1  instruction memory not ready this cycle
dmem_busy  input  1  data memory not ready this cycle
idex_memread  input  1  instruction in EX is a load
idex_rd  input  REG_W  destination register of instruction in EX
ifid_rs  input  REG_W  source 1 of instruction in ID
ifid_rt  input  REG_W  source 2 of instruction in ID
ifid_uses_rt  input  1  instruction in ID reads rt
ifid_valid  input  1  IF/ID holds a real (non-flushed) instruction
id_branch_taken  input  1  ID resolved a taken branch/jump
id_halt  input  1  ID decodes HLT
pc_en  output  1  PC write enable
ifid_en  output  1  IF/ID write enable
ifid_flush  output  1  value written into the IF/ID flush bit
idex_en  output  1  ID/EX write enable
idex_bubble  output  1  ID/EX captures a NOP instead of ID outputs
exmem_en  output  1  EX/MEM write enable
memwb_en  output  1  MEM/WB write enable
state  output  2  FSM state (RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3)
halted  output  1  high only in HALTED
stall_cnt  output  CNT_W  cycles with pc_en=0 outside HALTED, saturating

Behaviour:
- Reset: synchronous, active-high. It takes effect on the clock edge where rst=1: state<=RUN, drain counter<=0, stall_cnt<=0.
- While rst=1, outputs are forced: all enables=1, ifid_flush=0, idex_bubble=0, halted=0.
- Outputs are combinational from state and inputs; there is no added latency.
- freeze = (imem_busy | dmem_busy) and state != HALTED.
- hazard = ifid_valid & idex_memread & (idex_rd!=0) & (idex_rd==ifid_rs | (ifid_uses_rt & idex_rd==ifid_rt)).
- Priority, highest first: HALTED > freeze > DRAIN > hazard > halt decode > branch.
- RUN:
  - freeze: all five enables=0, flush=0, bubble=0; next state MEM_WAIT; the return state RUN is remembered.
  - hazard: pc_en=0, ifid_en=0, idex_bubble=1; idex/exmem/memwb_en=1. id_branch_taken and id_halt are ignored this cycle.
  - id_halt & ifid_valid: pc_en=0, ifid_en=1, ifid_flush=1, others=1; drain counter<=DRAIN_CYCLES-1; next state DRAIN.
  - id_branch_taken & ifid_valid: pc_en=1, ifid_en=1, ifid_flush=1 (kills the wrong-path fetch).
  - otherwise: all enables=1, flush=0, bubble=0.
- MEM_WAIT:
  - All enables=0 while freeze holds.
  - First cycle with freeze=0: go to the return state and evaluate that state's rules in the same cycle (no extra dead cycle).
  - Hazard/branch inputs are held stable by the frozen pipeline.
- DRAIN:
  - pc_en=0, ifid_en=1, ifid_flush=1, idex_en=1, idex_bubble=1, exmem_en=1, memwb_en=1.
  - Counter decrements each non-frozen cycle.
  - On a non-frozen cycle with counter==0: next state HALTED.
  - freeze inside DRAIN: enter MEM_WAIT with return state DRAIN; the counter holds.
- HALTED: all enables=0, halted=1, memory busy is ignored. Exit only via rst.
- stall_cnt increments on every cycle with pc_en=0 and state!=HALTED and rst=0. It saturates at all-ones (no wrap).
- Reset mid-MEM_WAIT or mid-DRAIN: the next cycle is RUN with counters cleared; the remembered return state is discarded.

Test Plan:
- Load-use: idex_memread=1, idex_rd=3, ifid_rs=3, ifid_valid=1 for one cycle -> pc_en=0, ifid_en=0, idex_bubble=1, idex_en=1; stall_cnt 0->1. Repeat with idex_rd=0 -> no stall.
- Branch vs hazard: id_branch_taken=1 alone -> ifid_flush=1, pc_en=1. Same cycle with hazard active -> hazard response, ifid_flush=0.
- Memory wait:
  - dmem_busy=1 for 4 cycles in RUN -> state=1, all enables=0 for 4 cycles; stall_cnt +=4; RUN enables restored on the cycle busy drops.
  - Busy plus a simultaneous hazard -> freeze wins.
- Halt drain:
  - id_halt=1 -> DRAIN; 3 non-frozen cycles later state=3, halted=1, all enables=0.
  - Insert imem_busy=1 for 2 cycles mid-drain -> HALTED arrives 2 cycles later.
- Saturation: preload by running 65540 stalled cycles (or force the counter to 0xFFFE) -> stall_cnt stops at 0xFFFF.
- Reset: assert rst during MEM_WAIT and during HALTED -> next cycle state=0, stall_cnt=0, halted=0, all enables=1.
